lower_rr_arbiter: RTL and testbench
===================================

// Module: lower_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one lower OR-combiner port (lower_ina/lower_inb -> lower_out)
//  between NREQ requesters. Grants one owner at a time, muxes the owner's ina/inb onto the
//  shared port, returns lower_out to the owner, and enforces a fairness hold limit.
//  Sits between requester agents and the autoinoutmodule instance "inst".
// PARAMETERS
//  NREQ      4   number of requesters (2..16)
//  MAX_HOLD  8   cycles an owner may hold the port while another requester waits (1..255)
// PORTS
//  clk           input   1     clock, all logic on rising edge
//  reset         input   1     synchronous, active-high reset
//  req           input   NREQ  level request per requester; held high for the whole ownership
//  req_ina       input   NREQ  per-requester value for lower_ina
//  req_inb       input   NREQ  per-requester value for lower_inb
//  lock          input   NREQ  per-requester no-preempt (present only with LOWER_ARB_LOCK_EN)
//  gnt           output  NREQ  one-hot grant, registered
//  busy          output  1     port owned (|gnt)
//  lower_ina     output  1     to inst.lower_ina
//  lower_inb     output  1     to inst.lower_inb
//  lower_out     input   1     from inst.lower_out
//  rsp_out       output  1     lower_out fanned back; valid only where gnt bit is set
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, busy=0, lower_ina=lower_inb=0, ptr=0, hold_cnt=0.
//  States: IDLE, OWN, GAP.
//   IDLE: if |req, pick first set req at or after ptr (rotating priority, wraps NREQ-1 -> 0);
//         next cycle gnt=onehot(winner), ptr=winner+1 mod NREQ, hold_cnt=0, -> OWN. Latency req->gnt = 1.
//   OWN:  lower_ina/inb = req_ina/inb[owner] combinationally, masked to 0 when gnt=0.
//         hold_cnt increments while any other req is high; saturates at MAX_HOLD; clears when none wait.
//         Owner drops req -> gnt=0 next edge, -> GAP.
//         hold_cnt==MAX_HOLD and another req pending -> preempt: gnt=0 next edge, -> GAP.
//         Release and preempt in the same cycle: treated as release (same outcome).
//         Owner alone never preempted; keeps port indefinitely.
//   GAP:  one dead cycle, gnt=0, port inputs 0; -> IDLE. Guarantees break-before-make.
//  Min re-grant spacing: 2 cycles (GAP+IDLE). req raised in GAP is arbitrated in IDLE.
//  rsp_out = lower_out, no registering; requesters qualify with their gnt bit.
//  gnt never has more than one bit set; gnt only asserted to a requester with req high at pick time.
//  Reset mid-ownership: gnt drops at the reset edge, ptr returns to 0.
//  hold_cnt width $clog2(MAX_HOLD+1); no overflow (saturating).
// CONFIGURATION
//  LOWER_ARB_LOCK_EN defined: lock port present; while lock[owner]=1 preemption is suppressed
//   (hold_cnt still saturates); preemption fires on the first cycle lock drops if still at MAX_HOLD.
//  Undefined: no lock port; preemption purely on hold_cnt.
// STRUCTURE
//  Package lower_arb_pkg: state_e {IDLE,OWN,GAP}; default NREQ/MAX_HOLD localparams; idx_t width func.
//  Sub-module lower_rr_pick: combinational rotating-priority picker (req, ptr -> onehot, idx, any).
//  Top holds FSM, ptr, hold_cnt, gnt register, port mux.
// TESTING
//  reset, req=4'b0101, ptr=0 -> cycle 1 gnt=0001, ptr=1; lower_ina follows req_ina[0].
//  req0 drops with req2 high -> gnt=0 for GAP+IDLE, then gnt=0100, ptr=3.
//  req0 and req1 held, MAX_HOLD=8 -> gnt0 for 9 cycles, preempt, gnt1 after 2 dead cycles.
//  ptr=3, req=4'b1001 -> grant 3, ptr wraps to 0; next grant goes to 0.
//  LOWER_ARB_LOCK_EN, lock[0]=1 for 20 cycles, req1 pending -> no preempt; lock drops -> gnt=0 next edge.
//  reset asserted while OWN -> gnt=0, lower_ina/inb=0 after that edge; re-arbitration starts from ptr=0.

Source files
------------

// File: rtl/lower_arb_pkg.sv
// lower_arb_pkg: shared types and defaults for the lower-port round-robin arbiter
package lower_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;
  localparam int DEF_NREQ = 4;
  localparam int DEF_MAX_HOLD = 8;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lower_rr_pick.sv
// lower_rr_pick: combinational rotating-priority picker, first request at or after ptr
module lower_rr_pick
  import lower_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW = idx_w(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] oh,
  output logic [IW-1:0]   idx,
  output logic            any
);
  // scan from ptr upward with wraparound, keep the first hit
  always_comb begin
    int j;
    oh = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      j = (j >= NREQ) ? j - NREQ : j;
      if (!any && req[j]) begin
        any = 1'b1;
        oh[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/lower_rr_arbiter.sv
// lower_rr_arbiter: round-robin owner of the shared lower port with hold limit; lock port with LOWER_ARB_LOCK_EN
module lower_rr_arbiter
  import lower_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_ina,
  input  logic [NREQ-1:0] req_inb,
`ifdef LOWER_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            lower_ina,
  output logic            lower_inb,
  input  logic            lower_out,
  output logic            rsp_out
);
  localparam int IW = idx_w(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_e state, state_nx;
  logic [IW-1:0] ptr, own, pick_idx;
  logic [HW-1:0] hold_cnt;
  logic [NREQ-1:0] pick_oh;
  logic pick_any, others, release_c, preempt, no_lock;
  lower_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(ptr),
    .oh(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
`ifdef LOWER_ARB_LOCK_EN
  assign no_lock = !lock[own];
`else
  assign no_lock = 1'b1;
`endif
  // ownership end conditions and next state; release and preempt share the same exit
  always_comb begin
    others = |(req & ~gnt);
    release_c = !req[own];
    preempt = (hold_cnt == HW'(MAX_HOLD)) && others && no_lock;
    state_nx = (state == IDLE) ? (pick_any ? OWN : IDLE) :
               (state == OWN) ? ((release_c || preempt) ? GAP : OWN) : IDLE;
  end
  // state, grant, rotation pointer and saturating hold counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= '0;
      own <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_any) begin
        gnt <= pick_oh;
        own <= pick_idx;
        ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        hold_cnt <= '0;
      end else if (state == OWN) begin
        gnt <= (release_c || preempt) ? '0 : gnt;
        hold_cnt <= !others ? '0 : (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
      end else begin
        gnt <= '0;
      end
    end
  end
  assign busy = |gnt;
  assign lower_ina = busy & req_ina[own];
  assign lower_inb = busy & req_inb[own];
  assign rsp_out = lower_out;
endmodule

// File: tb/tb_lower_rr_arbiter.sv
// tb_lower_rr_arbiter: directed table, corner sequences and random run against a queue-free ownership model
module tb_lower_rr_arbiter;
  localparam int N = 4;
  localparam int MAX_HOLD = 8;
  logic clk = 0;
  logic reset = 0;
  logic [N-1:0] req = '0, req_ina = '0, req_inb = '0, lock = '0, gnt;
  logic busy, lower_ina, lower_inb, lower_out = 0, rsp_out;
  int vectors = 0, miscompares = 0;
  int m_own = -1, m_cool = 0, m_ptr = 0, m_held = 0;
  typedef struct {
    logic [N-1:0] req, ina, inb, gnt;
    logic li;
  } vec_t;
  vec_t tbl[11];
  lower_rr_arbiter #(.NREQ(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_ina(req_ina),
    .req_inb(req_inb),
`ifdef LOWER_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt),
    .busy(busy),
    .lower_ina(lower_ina),
    .lower_inb(lower_inb),
    .lower_out(lower_out),
    .rsp_out(rsp_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    logic others, lk;
    if (reset) begin
      m_own = -1; m_cool = 0; m_ptr = 0; m_held = 0;
    end else if (m_own >= 0) begin
      others = (req & ~(N'(1) << m_own)) != 0;
`ifdef LOWER_ARB_LOCK_EN
      lk = lock[m_own];
`else
      lk = 1'b0;
`endif
      if (!req[m_own] || (m_held >= MAX_HOLD && others && !lk)) begin
        m_own = -1;
        m_cool = 1;
      end else m_held = others ? ((m_held < MAX_HOLD) ? m_held + 1 : MAX_HOLD) : 0;
    end else if (m_cool > 0) m_cool--;
    else if (req != 0) begin
      for (int i = 0; i < N; i++)
        if (req[(m_ptr + i) % N]) begin
          m_own = (m_ptr + i) % N;
          break;
        end
      m_ptr = (m_own + 1) % N;
      m_held = 0;
    end
  endtask
  task automatic step(input logic r, input logic [N-1:0] rq, ia, ib, input logic lo);
    logic [N-1:0] eg;
    reset = r; req = rq; req_ina = ia; req_inb = ib; lower_out = lo;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_own >= 0) ? N'(1) << m_own : '0;
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_busy", 32'(busy), 32'(eg != 0));
    chk("model_ina", 32'(lower_ina), (m_own >= 0) ? 32'(ia[m_own]) : 0);
    chk("model_inb", 32'(lower_inb), (m_own >= 0) ? 32'(ib[m_own]) : 0);
    chk("rsp_out", 32'(rsp_out), 32'(lo));
  endtask
  initial begin
    logic [N-1:0] rq, flip;
    tbl[0]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    tbl[1]  = '{4'b0101, 4'b0000, 4'b0001, 4'b0001, 1'b0};
    tbl[2]  = '{4'b0100, 4'b1111, 4'b1111, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0100, 4'b1111, 4'b1111, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1};
    tbl[5]  = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1001, 4'b1111, 4'b1111, 4'b0000, 1'b0};
    tbl[7]  = '{4'b1001, 4'b0111, 4'b0000, 4'b1000, 1'b0};
    tbl[8]  = '{4'b0001, 4'b1111, 4'b1111, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0001, 4'b1111, 4'b1111, 4'b0000, 1'b0};
    tbl[10] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    step(1, 4'b0101, 4'b1111, 4'b1111, 0);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ina", 32'(lower_ina), 0);
    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].req, tbl[i].ina, tbl[i].inb, 1'(i));
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_ina", i), 32'(lower_ina), 32'(tbl[i].li));
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 4'b0011, 4'b0001, 4'b0010, 0);
      chk($sformatf("hold%0d_gnt", i), 32'(gnt), 32'h1);
    end
    step(0, 4'b0011, 0, 0, 0);
    chk("preempt_gap", 32'(gnt), 0);
    step(0, 4'b0011, 0, 0, 0);
    chk("preempt_idle", 32'(gnt), 0);
    step(0, 4'b0011, 0, 0, 0);
    chk("preempt_next", 32'(gnt), 32'h2);
`ifdef LOWER_ARB_LOCK_EN
    step(1, 0, 0, 0, 0);
    lock = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step(0, 4'b0011, 0, 0, 0);
      chk($sformatf("lock%0d_gnt", i), 32'(gnt), 32'h1);
    end
    lock = 4'b0000;
    step(0, 4'b0011, 0, 0, 0);
    chk("unlock_preempt", 32'(gnt), 0);
`endif
    step(1, 0, 0, 0, 0);
    step(0, 4'b0100, 4'b0100, 4'b0100, 0);
    chk("mid_own_gnt", 32'(gnt), 32'h4);
    step(1, 4'b0100, 4'b0100, 4'b0100, 0);
    chk("mid_reset_gnt", 32'(gnt), 0);
    chk("mid_reset_ina", 32'(lower_ina), 0);
    chk("mid_reset_inb", 32'(lower_inb), 0);
    step(0, 4'b1100, 4'b1111, 4'b1111, 0);
    chk("post_reset_ptr0", 32'(gnt), 32'h4);
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
      rq ^= flip;
      if ($urandom_range(0, 15) == 0) lock = N'($urandom);
      step(($urandom_range(0, 499) == 0), rq, N'($urandom), N'($urandom), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
